// File: rtl/trace_pkg.sv
// trace_pkg: shared definitions for the writeback trace buffer.
//   REG_ZERO      - architectural $zero, never traced
//   TR_*_W        - entry field widths, ENTRY_W their sum
//   trace_entry_t - one captured register write {rd, data, pc, cyc}
//   pack_entry / unpack_entry - struct <-> flat storage vector
package trace_pkg;
  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int         REG_W     = 5;
  localparam int         TR_DATA_W = 32;
  localparam int         TR_PC_W   = 32;
  localparam int         TR_CYC_W  = 16;
  localparam int         ENTRY_W   = REG_W + TR_DATA_W + TR_PC_W + TR_CYC_W;

  typedef struct packed {
    logic [REG_W-1:0]     rd;
    logic [TR_DATA_W-1:0] data;
    logic [TR_PC_W-1:0]   pc;
    logic [TR_CYC_W-1:0]  cyc;
  } trace_entry_t;

  function automatic logic [ENTRY_W-1:0] pack_entry(input trace_entry_t e);
    return e;
  endfunction

  function automatic trace_entry_t unpack_entry(input logic [ENTRY_W-1:0] v);
    return trace_entry_t'(v);
  endfunction
endpackage

// File: rtl/trace_fifo_mem.sv
// trace_fifo_mem: DEPTH x W entry storage, one synchronous write port and
// one asynchronous read port. No reset: validity is tracked by the owner.
//   clk          - clock
//   we/waddr/wdata - write port (rising edge)
//   raddr/rdata  - combinational read port
module trace_fifo_mem
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [DEPTH-1:0][W-1:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: captures retired register writes {rd, data, pc, cycle}
// into a FIFO and presents them first-word-fall-through on a valid/ready port.
//   clk, rst (sync, active high), clear (flush FIFO + drop state)
//   wb_en/wb_reg/wb_data/wb_pc - writeback stage tap; rd==0 is ignored
//   out_valid/out_ready/out_*  - drain port, head entry registered
//   count     - occupancy
//   overflow  - sticky, a write was lost to a full FIFO
//   drop_cnt  - lost writes, saturates at 255
// Field widths are fixed by trace_pkg; DATA_W/PC_W/CYC_W must match it.
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = TR_DATA_W,
  parameter int PC_W   = TR_PC_W,
  parameter int CYC_W  = TR_CYC_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   wb_en,
  input  logic [4:0]             wb_reg,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic [PC_W-1:0]        wb_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4:0]             out_reg,
  output logic [DATA_W-1:0]      out_data,
  output logic [PC_W-1:0]        out_pc,
  output logic [CYC_W-1:0]       out_cycle,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CYC_W-1:0] cyc_q;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             full, push, pop, push_ok, drop, bypass;
  logic [ENTRY_W-1:0] rd_vec;
  trace_entry_t     new_e, rd_e, head_q;

  assign full    = (count == CNT_W'(DEPTH));
  assign push    = wb_en && (wb_reg != REG_ZERO);
  assign pop     = out_valid && out_ready;
  // A pop frees the slot in the same edge, so full+push+pop is not a drop.
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign rd_nxt  = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
  assign cnt_nxt = count + CNT_W'(push_ok) - CNT_W'(pop);
  // FIFO is empty after this edge's pop: the incoming write becomes the head
  // directly, since it is not yet readable from storage.
  assign bypass  = (count == CNT_W'(pop));

  assign new_e = '{rd: wb_reg, data: TR_DATA_W'(wb_data), pc: TR_PC_W'(wb_pc),
                   cyc: TR_CYC_W'(cyc_q)};
  assign rd_e  = unpack_entry(rd_vec);

  trace_fifo_mem #(.DEPTH(DEPTH), .W(ENTRY_W)) u_mem (
    .clk   (clk),
    .we    (push_ok && !rst && !clear),
    .waddr (wr_ptr),
    .wdata (pack_entry(new_e)),
    .raddr (rd_nxt),
    .rdata (rd_vec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      head_q   <= '0;
    end else begin
      cyc_q <= cyc_q + CYC_W'(1);
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        rd_ptr <= rd_nxt;
        count  <= cnt_nxt;
        if (drop) begin
          overflow <= 1'b1;
          if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
        // Head only reloads when something will be valid; otherwise it holds.
        if (cnt_nxt != '0) head_q <= bypass ? new_e : rd_e;
      end
    end
  end

  assign out_valid = (count != '0);
  assign out_reg   = head_q.rd;
  assign out_data  = DATA_W'(head_q.data);
  assign out_pc    = PC_W'(head_q.pc);
  assign out_cycle = CYC_W'(head_q.cyc);
endmodule

// File: tb/tb_wb_trace_buffer.sv
module tb_wb_trace_buffer;
  logic        clk = 1'b0;
  logic        rst, clear, wb_en, out_ready;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data, wb_pc;
  logic        out_valid, overflow;
  logic [4:0]  out_reg;
  logic [31:0] out_data, out_pc;
  logic [15:0] out_cycle;
  logic [4:0]  count;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;
  int tb_cyc = 0;   // unwrapped cycle number since reset release

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) tb_cyc <= 0;
    else     tb_cyc <= tb_cyc + 1;
  end

  wb_trace_buffer #(.DEPTH(16), .DATA_W(32), .PC_W(32), .CYC_W(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .wb_en(wb_en), .wb_reg(wb_reg),
    .wb_data(wb_data), .wb_pc(wb_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_reg(out_reg), .out_data(out_data), .out_pc(out_pc), .out_cycle(out_cycle),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear;
    clear = 1'b1; wb_en = 1'b0; out_ready = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  task automatic push_n(input int n, input int base);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      wb_en = 1'b1; wb_reg = 5'(1 + (i % 31)); wb_data = 32'(base + i); wb_pc = 32'(i * 4);
      tick();
    end
    wb_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; clear = 1'b0; wb_en = 1'b0; wb_reg = '0; wb_data = '0; wb_pc = '0;
    out_ready = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
    checks++; if ({out_reg, out_data, out_pc, out_cycle} !== '0) begin
      errors++; $display("FAIL reset_outs: got reg=%0h data=%0h pc=%0h cyc=%0h expected all 0",
                         out_reg, out_data, out_pc, out_cycle); end
    rst = 1'b0;
  endtask

  task automatic test_single_write;
    tick(); tick(); tick();   // counter now 3
    wb_en = 1'b1; wb_reg = 5'd16; wb_data = 32'd5; wb_pc = 32'h0; out_ready = 1'b1;
    tick();
    wb_en = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b expected 1", out_valid); end
    checks++; if (out_reg !== 5'd16) begin errors++; $display("FAIL single_reg: got %0d expected 16", out_reg); end
    checks++; if (out_data !== 32'd5) begin errors++; $display("FAIL single_data: got %0h expected 5", out_data); end
    checks++; if (out_pc !== 32'd0) begin errors++; $display("FAIL single_pc: got %0h expected 0", out_pc); end
    checks++; if (out_cycle !== 16'd3) begin errors++; $display("FAIL single_cycle: got %0d expected 3", out_cycle); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle: got %0b expected 0", out_valid); end
    checks++; if (out_data !== 32'd5) begin errors++; $display("FAIL single_hold: got %0h expected 5", out_data); end
    out_ready = 1'b0;
  endtask

  task automatic test_zero_filter;
    for (int i = 0; i < 10; i++) begin
      wb_en = 1'b1; wb_reg = 5'd0; wb_data = 32'(100 + i);
      tick();
      checks++; if (count !== 5'd0 || out_valid !== 1'b0 || drop_cnt !== 8'd0) begin
        errors++; $display("FAIL zero_filter[%0d]: got count=%0d valid=%0b drop=%0d expected 0/0/0",
                           i, count, out_valid, drop_cnt); end
    end
    wb_en = 1'b0;
  endtask

  task automatic test_overflow;
    do_clear();
    push_n(20, 1);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
    checks++; if (drop_cnt !== 8'd4) begin errors++; $display("FAIL ovf_drop: got %0d expected 4", drop_cnt); end
    tick(); tick();
    checks++; if (out_data !== 32'd1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL ovf_head_stable: got data=%0d valid=%0b expected 1/1", out_data, out_valid); end
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
        errors++; $display("FAIL ovf_drain[%0d]: got valid=%0b data=%0d expected 1/%0d", i, out_valid, out_data, i); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %0b expected 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_push_pop;
    do_clear();
    push_n(16, 1);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fpp_fill: got %0d expected 16", count); end
    for (int k = 1; k <= 3; k++) begin
      wb_en = 1'b1; wb_reg = 5'd7; wb_data = 32'(100 + k); out_ready = 1'b1;
      checks++; if (out_data !== 32'(k)) begin
        errors++; $display("FAIL fpp_pop[%0d]: got %0d expected %0d", k, out_data, k); end
      tick();
      checks++; if (count !== 5'd16 || drop_cnt !== 8'd0) begin
        errors++; $display("FAIL fpp_count[%0d]: got count=%0d drop=%0d expected 16/0", k, count, drop_cnt); end
    end
    wb_en = 1'b0; out_ready = 1'b0;
    checks++; if (out_data !== 32'd4) begin errors++; $display("FAIL fpp_next_head: got %0d expected 4", out_data); end
  endtask

  task automatic test_clear_wrap;
    do_clear();
    push_n(17, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    out_ready = 1'b0;
    checks++; if (count !== 5'd5 || overflow !== 1'b1) begin
      errors++; $display("FAIL clr_setup: got count=%0d ovf=%0b expected 5/1", count, overflow); end
    clear = 1'b1; wb_en = 1'b1; wb_reg = 5'd9; wb_data = 32'hDEAD; out_ready = 1'b1;
    tick();
    clear = 1'b0; wb_en = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 5'd0 || overflow !== 1'b0 || drop_cnt !== 8'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL clr_state: got count=%0d ovf=%0b drop=%0d valid=%0b expected 0/0/0/0",
                         count, overflow, drop_cnt, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0 || count !== 5'd0) begin
      errors++; $display("FAIL clr_push_absent: got valid=%0b count=%0d expected 0/0", out_valid, count); end
    for (int n = 0; n < 70000 && tb_cyc != 65537; n++) tick();
    checks++; if (tb_cyc != 65537) begin errors++; $display("FAIL wrap_reach: got %0d expected 65537", tb_cyc); end
    wb_en = 1'b1; wb_reg = 5'd3; wb_data = 32'd7;
    tick();
    wb_en = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_cycle !== 16'd1) begin
      errors++; $display("FAIL wrap_stamp: got valid=%0b cycle=%0d expected 1/1", out_valid, out_cycle); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] q[$];
    int drops = 0;
    logic rdy, mpop;
    int sz;
    do_clear();
    for (int i = 0; i < 40; i++) begin
      checks++; if (out_valid !== (q.size() != 0)) begin
        errors++; $display("FAIL bp_valid[%0d]: got %0b expected %0b", i, out_valid, q.size() != 0); end
      rdy = (i % 2) == 1;
      wb_en = 1'b1; wb_reg = 5'(1 + (i % 31)); wb_data = 32'(1000 + i); out_ready = rdy;
      sz = q.size();
      mpop = rdy && (sz != 0);
      if (mpop) begin
        checks++; if (out_data !== q[0]) begin
          errors++; $display("FAIL bp_order[%0d]: got %0d expected %0d", i, out_data, q[0]); end
        void'(q.pop_front());
      end
      if (sz < 16 || mpop) q.push_back(32'(1000 + i));
      else drops++;
      tick();
    end
    wb_en = 1'b0;
    checks++; if (drop_cnt !== 8'(drops)) begin errors++; $display("FAIL bp_drop: got %0d expected %0d", drop_cnt, drops); end
    checks++; if (count !== 5'(q.size())) begin errors++; $display("FAIL bp_count: got %0d expected %0d", count, q.size()); end
    out_ready = 1'b1;
    for (int n = 0; n < 40 && q.size() != 0; n++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== q[0]) begin
        errors++; $display("FAIL bp_drain: got valid=%0b data=%0d expected 1/%0d", out_valid, out_data, q[0]); end
      void'(q.pop_front());
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %0b expected 0", out_valid); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_zero_filter();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_clear_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
